// File: rtl/icache_nway.sv
// N-way set-associative instruction cache returning the raw 32-bit word at any halfword address,
// filling one or two lines byte-by-byte from the memory controller with round-robin replacement.
module icache_nway #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned SETS       = 128,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hci_rdy,
  input  logic                  flush,
  input  logic                  instruction_get_en,
  input  logic [ADDR_WIDTH-1:0] instruction_addr,
  input  logic                  memory_out_en,
  input  logic [7:0]            memory_content,
  output logic                  idle,
  output logic                  instruction_out_en,
  output logic [31:0]           instruction,
  output logic                  c_instruction,
  output logic                  memory_get_en,
  output logic [ADDR_WIDTH-1:0] memory_addr
);
  localparam int unsigned OFF = $clog2(LINE_BYTES);
  localparam int unsigned IW  = $clog2(SETS);
  localparam int unsigned TW  = ADDR_WIDTH - OFF - IW;
  localparam int unsigned WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LW  = ADDR_WIDTH - OFF;

  typedef enum logic [1:0] {StIdle, StFillA, StFillB, StResp} state_e;
  state_e state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WW-1:0]   ptr_q;
  logic [TW-1:0]             tag_q  [SETS][WAYS];
  logic [7:0]                data_q [SETS][WAYS][LINE_BYTES];

  logic [ADDR_WIDTH-1:0] a_q, b_q, cur_a, cur_b;
  logic [OFF-1:0]        cnt_q, off_a, off_a1, off_a2, off_a3, off_b, off_b1;
  logic [WW-1:0]         fill_way_q, fill_way, victim, way_a, way_b, next_ptr;
  logic [IW-1:0]         idx_a, idx_b, fill_idx;
  logic [TW-1:0]         tag_a, tag_b, fill_tag;
  logic [LW-1:0]         fill_line;
  logic                  hit_a, hit_b, same_line, uncomp_a, need_b, from_ptr;
  logic                  fill_active, last_beat, capture, accept, respond;
  logic [31:0]           word;

  // In IDLE the lookup runs on the incoming address so a hit answers next cycle.
  always_comb begin
    cur_a     = (state_q == StIdle) ? (instruction_addr & ~ADDR_WIDTH'(1)) : a_q;
    cur_b     = cur_a + ADDR_WIDTH'(2);
    idx_a     = cur_a[OFF+IW-1:OFF];
    tag_a     = cur_a[ADDR_WIDTH-1:OFF+IW];
    off_a     = cur_a[OFF-1:0];
    idx_b     = cur_b[OFF+IW-1:OFF];
    tag_b     = cur_b[ADDR_WIDTH-1:OFF+IW];
    off_b     = cur_b[OFF-1:0];
    off_a1    = off_a + OFF'(1);
    off_a2    = off_a + OFF'(2);
    off_a3    = off_a + OFF'(3);
    off_b1    = off_b + OFF'(1);
    same_line = (cur_a[ADDR_WIDTH-1:OFF] == cur_b[ADDR_WIDTH-1:OFF]);
    hit_a     = 1'b0;
    way_a     = '0;
    hit_b     = 1'b0;
    way_b     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_a][w] && tag_q[idx_a][w] == tag_a) begin
        hit_a = 1'b1;
        way_a = WW'(w);
      end
      if (valid_q[idx_b][w] && tag_q[idx_b][w] == tag_b) begin
        hit_b = 1'b1;
        way_b = WW'(w);
      end
    end
    uncomp_a  = (data_q[idx_a][way_a][off_a][1:0] == 2'b11);
    need_b    = !same_line && !hit_b && uncomp_a;
    word[15:0] = {data_q[idx_a][way_a][off_a1], data_q[idx_a][way_a][off_a]};
    word[31:16] = same_line ? {data_q[idx_a][way_a][off_a3], data_q[idx_a][way_a][off_a2]}
                            : {data_q[idx_b][way_b][off_b1], data_q[idx_b][way_b][off_b]};
  end

  // Victim: lowest invalid way, else the round-robin pointer.
  always_comb begin
    fill_line = (state_q == StFillB) ? b_q[ADDR_WIDTH-1:OFF] : a_q[ADDR_WIDTH-1:OFF];
    fill_idx  = fill_line[IW-1:0];
    fill_tag  = fill_line[LW-1:IW];
    victim    = ptr_q[fill_idx];
    from_ptr  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_idx][w]) begin
        victim   = WW'(w);
        from_ptr = 1'b0;
      end
    end
    next_ptr    = (ptr_q[fill_idx] == WW'(WAYS - 1)) ? '0 : ptr_q[fill_idx] + WW'(1);
    fill_way    = (cnt_q == '0) ? victim : fill_way_q;
    fill_active = (state_q == StFillA) || (state_q == StFillB);
    last_beat   = memory_out_en && (cnt_q == OFF'(LINE_BYTES - 1));
    capture     = fill_active && hci_rdy && memory_out_en && !flush;
    accept      = (state_q == StIdle) && hci_rdy && instruction_get_en && !flush;
    respond     = hci_rdy && !flush &&
                  ((accept && hit_a && !need_b) || (state_q == StResp));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else if (hci_rdy) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (instruction_get_en) state_d = !hit_a ? StFillA : (need_b ? StFillB : StIdle);
        StFillA: if (last_beat) state_d = need_b ? StFillB : StResp;
        StFillB: if (last_beat) state_d = StResp;
        StResp:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    idle          = (state_q == StIdle);
    memory_get_en = fill_active && hci_rdy && !last_beat;
    memory_addr   = fill_active ? {fill_line, {OFF{1'b0}}} + ADDR_WIDTH'(cnt_q)
                                  + ADDR_WIDTH'(memory_out_en) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      fill_way_q <= '0;
      valid_q    <= '0;
      ptr_q      <= '0;
    end else if (hci_rdy) begin
      if (flush) begin
        valid_q <= '0;
        ptr_q   <= '0;
        cnt_q   <= '0;
      end else begin
        if (accept) begin
          a_q <= cur_a;
          b_q <= cur_b;
        end
        if (capture) begin
          cnt_q <= cnt_q + OFF'(1);
          if (cnt_q == '0) begin
            valid_q[fill_idx][fill_way] <= 1'b1;
            fill_way_q                  <= victim;
            if (from_ptr) ptr_q[fill_idx] <= next_ptr;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      data_q[fill_idx][fill_way][cnt_q] <= memory_content;
      if (cnt_q == '0) tag_q[fill_idx][fill_way] <= fill_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_out_en <= 1'b0;
      instruction        <= '0;
      c_instruction      <= 1'b0;
    end else if (hci_rdy) begin
      instruction_out_en <= respond;
      if (respond) begin
        instruction   <= word;
        c_instruction <= (word[1:0] != 2'b11);
      end
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: cold/cross-line/compressed fills, replacement, flush, stall, reset.
module tb_icache_nway;
  logic        clk = 1'b0;
  logic        rst, hci_rdy, flush, instruction_get_en, memory_out_en;
  logic [16:0] instruction_addr, memory_addr;
  logic [7:0]  memory_content;
  logic        idle, instruction_out_en, c_instruction, memory_get_en;
  logic [31:0] instruction;
  logic [7:0]  mem [0:2047];
  int          npass = 0;
  int          ntotal = 0;

  icache_nway #(.ADDR_WIDTH(17), .SETS(128), .WAYS(2), .LINE_BYTES(4)) dut (
    .clk(clk), .rst(rst), .hci_rdy(hci_rdy), .flush(flush),
    .instruction_get_en(instruction_get_en), .instruction_addr(instruction_addr),
    .memory_out_en(memory_out_en), .memory_content(memory_content), .idle(idle),
    .instruction_out_en(instruction_out_en), .instruction(instruction),
    .c_instruction(c_instruction), .memory_get_en(memory_get_en), .memory_addr(memory_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic fetch(input logic [16:0] a);
    instruction_get_en = 1'b1;
    instruction_addr   = a;
    #1 chk("idle_at_req", {31'b0, idle}, 32'd1);
    @(negedge clk);
    instruction_get_en = 1'b0;
  endtask

  // Serve bytes base+first..base+last, checking address, look-ahead and get_en drop.
  task automatic beats(input logic [16:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      memory_out_en = 1'b0;
      #1 chk("mem_addr", {15'b0, memory_addr}, {15'b0, base} + k);
      chk("mem_get", {31'b0, memory_get_en}, 32'd1);
      memory_content = mem[11'(base + 17'(k))];
      memory_out_en  = 1'b1;
      #1;
      if (k == 3) chk("get_drop_last", {31'b0, memory_get_en}, 32'd0);
      else chk("lookahead", {15'b0, memory_addr}, {15'b0, base} + k + 1);
      @(negedge clk);
    end
    memory_out_en = 1'b0;
  endtask

  task automatic expect_resp(input logic [31:0] w, input logic [31:0] mask, input logic c);
    #1 chk("resp_no_out", {31'b0, instruction_out_en}, 32'd0);
    chk("resp_no_get", {31'b0, memory_get_en}, 32'd0);
    @(negedge clk);
    #1 chk("out_en", {31'b0, instruction_out_en}, 32'd1);
    chk("instr", instruction & mask, w);
    chk("c_instr", {31'b0, c_instruction}, {31'b0, c});
    chk("idle_after", {31'b0, idle}, 32'd1);
    @(negedge clk);
    #1 chk("out_pulse", {31'b0, instruction_out_en}, 32'd0);
  endtask

  task automatic expect_hit(input logic [31:0] w, input logic c);
    #1 chk("hit_out_en", {31'b0, instruction_out_en}, 32'd1);
    chk("hit_instr", instruction, w);
    chk("hit_c", {31'b0, c_instruction}, {31'b0, c});
    chk("hit_no_get", {31'b0, memory_get_en}, 32'd0);
  endtask

  task automatic do_flush;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]}         = {8'h13, 8'h05, 8'h00, 8'h00};
    {mem[4], mem[5], mem[6], mem[7]}         = {8'h93, 8'h05, 8'h10, 8'h00};
    {mem[8], mem[9], mem[10], mem[11]}       = {8'h00, 8'h00, 8'h01, 8'h45};
    {mem[16], mem[17], mem[18], mem[19]}     = {8'h93, 8'h00, 8'h10, 8'h00};
    {mem[32], mem[33], mem[34], mem[35]}     = {8'h13, 8'h00, 8'h00, 8'h00};
    {mem[512], mem[513], mem[514], mem[515]} = {8'hb7, 8'h02, 8'h00, 8'h00};
    {mem[1024], mem[1025], mem[1026], mem[1027]} = {8'h17, 8'h03, 8'h00, 8'h00};
    rst = 1'b1; hci_rdy = 1'b1; flush = 1'b0; instruction_get_en = 1'b0;
    instruction_addr = '0; memory_out_en = 1'b0; memory_content = '0;
    @(negedge clk);
    #1 chk("rst_idle", {31'b0, idle}, 32'd1);
    chk("rst_out_en", {31'b0, instruction_out_en}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_get", {31'b0, memory_get_en}, 32'd0);
    chk("rst_addr", {15'b0, memory_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss then hit
    fetch(17'h0); beats(17'h0, 0, 3); expect_resp(32'h00000513, 32'hffffffff, 1'b0);
    fetch(17'h0); expect_hit(32'h00000513, 1'b0);
    @(negedge clk);
    fetch(17'h4); beats(17'h4, 0, 3); expect_resp(32'h00100593, 32'hffffffff, 1'b0);
    // Cross-line hit
    fetch(17'h2); expect_hit(32'h05930000, 1'b1);

    // Cross-line two-line fill after flush
    do_flush;
    mem[2] = 8'h13; mem[3] = 8'h05;
    fetch(17'h2); beats(17'h0, 0, 3); beats(17'h4, 0, 3);
    expect_resp(32'h05930513, 32'hffffffff, 1'b0);

    // Compressed first halfword skips the second line
    fetch(17'ha); beats(17'h8, 0, 3); expect_resp(32'h00004501, 32'h0000ffff, 1'b1);

    // Round-robin replacement in set 0
    do_flush;
    fetch(17'h000); beats(17'h000, 0, 3); expect_resp(32'h05130513, 32'hffffffff, 1'b0);
    fetch(17'h200); beats(17'h200, 0, 3); expect_resp(32'h000002b7, 32'hffffffff, 1'b0);
    fetch(17'h400); beats(17'h400, 0, 3); expect_resp(32'h00000317, 32'hffffffff, 1'b0);
    fetch(17'h200); expect_hit(32'h000002b7, 1'b0);
    @(negedge clk);
    fetch(17'h400); expect_hit(32'h00000317, 1'b0);
    @(negedge clk);
    fetch(17'h000); beats(17'h000, 0, 3); expect_resp(32'h05130513, 32'hffffffff, 1'b0);
    fetch(17'h400); expect_hit(32'h00000317, 1'b0);
    @(negedge clk);

    // Flush mid-fill
    fetch(17'h10); beats(17'h10, 0, 1);
    flush = 1'b1;
    #1 chk("flush_get_still", {31'b0, memory_get_en}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_get_drop", {31'b0, memory_get_en}, 32'd0);
    chk("flush_idle", {31'b0, idle}, 32'd1);
    chk("flush_no_out", {31'b0, instruction_out_en}, 32'd0);
    @(negedge clk);
    #1 chk("flush_no_out2", {31'b0, instruction_out_en}, 32'd0);

    // Refetch misses; stall 5 cycles mid-fill
    fetch(17'h10); beats(17'h10, 0, 1);
    hci_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_get", {31'b0, memory_get_en}, 32'd0);
      chk("stall_addr", {15'b0, memory_addr}, 32'h12);
      chk("stall_busy", {31'b0, idle}, 32'd0);
      @(negedge clk);
    end
    hci_rdy = 1'b1;
    beats(17'h10, 2, 3); expect_resp(32'h00100093, 32'hffffffff, 1'b0);

    // Asynchronous reset mid-fill
    fetch(17'h20); beats(17'h20, 0, 0);
    #2 rst = 1'b1;
    #1 chk("arst_idle", {31'b0, idle}, 32'd1);
    chk("arst_get", {31'b0, memory_get_en}, 32'd0);
    chk("arst_addr", {15'b0, memory_addr}, 32'd0);
    chk("arst_out_en", {31'b0, instruction_out_en}, 32'd0);
    chk("arst_instr", instruction, 32'd0);
    chk("arst_c", {31'b0, c_instruction}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch(17'h0); beats(17'h0, 0, 3); expect_resp(32'h05130513, 32'hffffffff, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
